regfile_write_decoder: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_write_decoder_onehot_decode.sv | 20 ++
 rtl/regfile_write_decoder.sv | 112 +++++++++++
 tb/tb_regfile_write_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the port-index width helper used by the
// write decoder and the register file itself.
package regfile_pkg;

  localparam int unsigned REGFILE_ADDR_WIDTH = 5;
  localparam int unsigned REGFILE_DEPTH      = 32;

  // Width of a port index; a single port still needs one bit of select.
  function automatic int unsigned piw(input int unsigned num_ports);
    if (num_ports <= 1) begin
      return 1;
    end
    return $clog2(num_ports);
  endfunction

endpackage

// File: rtl/regfile_write_decoder_onehot_decode.sv
// Combinational address decoder: one-hot DEPTH vector when enabled, zero otherwise.
module onehot_decode
  import regfile_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DEPTH-1:0]      onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_decoder.sv
// Registered multi-port write decoder: per-register write enable and winning
// source port, fixed last-port-wins priority, collision flag and saturating count.
module regfile_write_decoder
  import regfile_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH  = REGFILE_ADDR_WIDTH,
  parameter  int unsigned NUM_PORTS   = 2,
  parameter  bit          ZERO_REG_EN = 1'b1,
  parameter  int unsigned CNT_WIDTH   = 8,
  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH,
  localparam int unsigned PIW         = piw(NUM_PORTS)
) (
  input  logic                            clock,
  input  logic                            ctrl_reset,
  input  logic                            ctrl_stall,
  input  logic [NUM_PORTS-1:0]            ctrl_writeEnable,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DEPTH-1:0]                decode_we,
  output logic [DEPTH*PIW-1:0]            decode_src,
  output logic                            conflict,
  output logic [CNT_WIDTH-1:0]            conflict_count
);

  logic [NUM_PORTS-1:0]  live;
  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [DEPTH-1:0]      port_hot  [NUM_PORTS];

  logic [DEPTH-1:0]     scan_we;
  logic [DEPTH*PIW-1:0] scan_src;
  logic                 collide;

  logic [DEPTH-1:0]     decode_we_d,      decode_we_q;
  logic [DEPTH*PIW-1:0] decode_src_d,     decode_src_q;
  logic                 conflict_d,       conflict_q;
  logic [CNT_WIDTH-1:0] conflict_count_d, conflict_count_q;

  // A port writing register 0 is treated exactly like a disabled port when
  // register 0 is hardwired, so it can neither win nor collide.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_addr[p] = ctrl_writeReg[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign live[p]      = ctrl_writeEnable[p] &
                          (!ZERO_REG_EN || (port_addr[p] != '0));

    onehot_decode #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_onehot_decode (
      .en     (live[p]),
      .addr   (port_addr[p]),
      .onehot (port_hot[p])
    );
  end

  // Scanning upward lets the highest-index live port overwrite the select.
  always_comb begin
    scan_we  = '0;
    scan_src = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_hot[p][r]) begin
          scan_we[r]                = 1'b1;
          scan_src[r*PIW +: PIW]    = PIW'(p);
        end
      end
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = p + 1; q < NUM_PORTS; q++) begin
        if (live[p] && live[q] && (port_addr[p] == port_addr[q])) begin
          collide = 1'b1;
        end
      end
    end
  end

  always_comb begin
    decode_we_d      = decode_we_q;
    decode_src_d     = decode_src_q;
    conflict_d       = conflict_q;
    conflict_count_d = conflict_count_q;
    if (!ctrl_stall) begin
      decode_we_d  = scan_we;
      decode_src_d = scan_src;
      conflict_d   = collide;
      if (collide && (conflict_count_q != {CNT_WIDTH{1'b1}})) begin
        conflict_count_d = conflict_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      decode_we_q      <= '0;
      decode_src_q     <= '0;
      conflict_q       <= 1'b0;
      conflict_count_q <= '0;
    end else begin
      decode_we_q      <= decode_we_d;
      decode_src_q     <= decode_src_d;
      conflict_q       <= conflict_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign decode_we      = decode_we_q;
  assign decode_src     = decode_src_q;
  assign conflict       = conflict_q;
  assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Bench for regfile_write_decoder: default build, a 2-bit-counter build sharing
// its inputs, and a 4-port 3-bit-address build, all against a reference model.
module tb_regfile_write_decoder;

  logic clock;
  logic ctrl_reset;
  logic ctrl_stall;

  logic [1:0]      en0;
  logic [1:0][4:0] addr0;
  logic [3:0]      en4;
  logic [3:0][2:0] addr4;

  logic [31:0] d0_we,  d1_we;
  logic [31:0] d0_src, d1_src;
  logic        d0_conf, d1_conf;
  logic [7:0]  d0_cnt;
  logic [1:0]  d1_cnt;
  logic [7:0]  d4_we;
  logic [15:0] d4_src;
  logic        d4_conf;
  logic [7:0]  d4_cnt;

  logic [31:0] exp0_we;
  logic [31:0] exp0_src;
  logic        exp0_conf;
  int          exp0_cnt;
  int          exp1_cnt;
  logic [7:0]  exp4_we;
  logic [15:0] exp4_src;
  logic        exp4_conf;
  int          exp4_cnt;

  int n_asserts;
  int n_fail;

  regfile_write_decoder dut0 (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_stall       (ctrl_stall),
    .ctrl_writeEnable (en0),
    .ctrl_writeReg    (addr0),
    .decode_we        (d0_we),
    .decode_src       (d0_src),
    .conflict         (d0_conf),
    .conflict_count   (d0_cnt)
  );

  regfile_write_decoder #(.CNT_WIDTH(2)) dut1 (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_stall       (ctrl_stall),
    .ctrl_writeEnable (en0),
    .ctrl_writeReg    (addr0),
    .decode_we        (d1_we),
    .decode_src       (d1_src),
    .conflict         (d1_conf),
    .conflict_count   (d1_cnt)
  );

  regfile_write_decoder #(.ADDR_WIDTH(3), .NUM_PORTS(4)) dut4 (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_stall       (ctrl_stall),
    .ctrl_writeEnable (en4),
    .ctrl_writeReg    (addr4),
    .decode_we        (d4_we),
    .decode_src       (d4_src),
    .conflict         (d4_conf),
    .conflict_count   (d4_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: tally live writes per address; the last live port seen wins,
  // and any address hit twice or more makes the cycle a collision.
  task automatic model_eval(input int np, input logic [3:0] en,
                            input logic [3:0][4:0] a,
                            output logic [31:0] we,
                            output logic [31:0][1:0] src,
                            output logic coll);
    int hits [32];
    we   = '0;
    src  = '0;
    coll = 1'b0;
    for (int i = 0; i < 32; i++) hits[i] = 0;
    for (int p = 0; p < np; p++) begin
      if (en[p] && a[p] != 5'd0) begin
        hits[a[p]]++;
        we[a[p]]  = 1'b1;
        src[a[p]] = 2'(p);
      end
    end
    for (int i = 0; i < 32; i++) if (hits[i] >= 2) coll = 1'b1;
  endtask

  task automatic check_all();
    check("we0",   64'(d0_we),   64'(exp0_we));
    check("src0",  64'(d0_src),  64'(exp0_src));
    check("conf0", 64'(d0_conf), 64'(exp0_conf));
    check("cnt0",  64'(d0_cnt),  64'(exp0_cnt));
    check("we1",   64'(d1_we),   64'(exp0_we));
    check("cnt1",  64'(d1_cnt),  64'(exp1_cnt));
    check("we4",   64'(d4_we),   64'(exp4_we));
    check("src4",  64'(d4_src),  64'(exp4_src));
    check("conf4", 64'(d4_conf), 64'(exp4_conf));
    check("cnt4",  64'(d4_cnt),  64'(exp4_cnt));
  endtask

  task automatic step(input logic rst, input logic stl);
    logic [31:0]      m_we;
    logic [31:0][1:0] m_src;
    logic             m_coll;
    logic [3:0][4:0]  a;
    ctrl_reset = rst;
    ctrl_stall = stl;
    @(posedge clock);
    if (rst) begin
      exp0_we = '0; exp0_src = '0; exp0_conf = 1'b0; exp0_cnt = 0; exp1_cnt = 0;
      exp4_we = '0; exp4_src = '0; exp4_conf = 1'b0; exp4_cnt = 0;
    end else if (!stl) begin
      a = '0;
      a[0] = addr0[0];
      a[1] = addr0[1];
      model_eval(2, {2'b00, en0}, a, m_we, m_src, m_coll);
      exp0_we   = m_we;
      for (int r = 0; r < 32; r++) exp0_src[r] = m_src[r][0];
      exp0_conf = m_coll;
      if (m_coll) begin
        if (exp0_cnt < 255) exp0_cnt++;
        if (exp1_cnt < 3) exp1_cnt++;
      end
      for (int p = 0; p < 4; p++) a[p] = {2'b00, addr4[p]};
      model_eval(4, en4, a, m_we, m_src, m_coll);
      exp4_we = m_we[7:0];
      for (int r = 0; r < 8; r++) exp4_src[r*2 +: 2] = m_src[r];
      exp4_conf = m_coll;
      if (m_coll && exp4_cnt < 255) exp4_cnt++;
    end
    #1;
    check_all();
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    ctrl_reset = 1'b1;
    ctrl_stall = 1'b0;
    en4   = 4'hf;
    addr4 = 12'($urandom);
    en0   = 2'b11;
    addr0 = 10'($urandom);

    // Reset held two cycles with live random requests.
    step(1'b1, 1'b0);
    addr0 = 10'($urandom);
    step(1'b1, 1'b0);
    check("rst_we", 64'(d0_we), 64'd0);
    check("rst_cnt", 64'(d0_cnt), 64'd0);

    // Single writes across every address; port 1 disabled.
    en4 = 4'h0;
    for (int a = 0; a < 32; a++) begin
      en0      = 2'b01;
      addr0[0] = 5'(a);
      addr0[1] = 5'($urandom);
      step(1'b0, 1'b0);
      check("single_we", 64'(d0_we), (a == 0) ? 64'd0 : (64'd1 << a));
    end

    // Distinct addresses.
    en0 = 2'b11; addr0[0] = 5'd3; addr0[1] = 5'd12;
    step(1'b0, 1'b0);
    check("dual_we", 64'(d0_we), 64'h1008);
    check("dual_src12", 64'(d0_src[12]), 64'd1);
    check("dual_src3", 64'(d0_src[3]), 64'd0);

    // Collision on 9, then on 0 (suppressed).
    addr0[0] = 5'd9; addr0[1] = 5'd9;
    step(1'b0, 1'b0);
    check("coll_we", 64'(d0_we), 64'h200);
    check("coll_src9", 64'(d0_src[9]), 64'd1);
    check("coll_conf", 64'(d0_conf), 64'd1);
    check("coll_cnt", 64'(d0_cnt), 64'd1);
    addr0[0] = 5'd0; addr0[1] = 5'd0;
    step(1'b0, 1'b0);
    check("zero_we", 64'(d0_we), 64'd0);
    check("zero_conf", 64'(d0_conf), 64'd0);
    check("zero_cnt", 64'(d0_cnt), 64'd1);

    // Stall holds outputs; stalled request is not replayed.
    en0 = 2'b01; addr0[0] = 5'd5;
    step(1'b0, 1'b0);
    en0 = 2'b10; addr0[1] = 5'd6;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check("stall_we", 64'(d0_we), 64'h20);
    end
    en0 = 2'b00;
    step(1'b0, 1'b0);
    check("unstall_we", 64'(d0_we), 64'd0);

    // Saturation of the 2-bit counter.
    step(1'b1, 1'b0);
    en0 = 2'b11;
    for (int i = 0; i < 5; i++) begin
      addr0[0] = 5'($urandom_range(1, 31));
      addr0[1] = addr0[0];
      step(1'b0, 1'b0);
      check("sat_cnt1", 64'(d1_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end

    // Four ports on one address.
    en0 = 2'b00;
    en4 = 4'hf;
    addr4 = {3'd6, 3'd6, 3'd6, 3'd6};
    step(1'b0, 1'b0);
    check("p4_we", 64'(d4_we), 64'h40);
    check("p4_src6", 64'(d4_src[12 +: 2]), 64'd3);
    check("p4_conf", 64'(d4_conf), 64'd1);

    // Reset during a stall clears on that edge.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("rst_stall_we4", 64'(d4_we), 64'd0);

    // Randomized traffic with occasional stall and reset.
    for (int i = 0; i < 400; i++) begin
      en0 = 2'($urandom);
      en4 = 4'($urandom);
      for (int p = 0; p < 2; p++)
        addr0[p] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      for (int p = 0; p < 4; p++)
        addr4[p] = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
